// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: sequencer for the 32x32 2R/1W register file.
// Option: define RF_ACCESS_ZERO_REG_EN to hardwire register 0 to zero.
module rf_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [ADDR_WIDTH-1:0] REQ_RS,
  input  logic [ADDR_WIDTH-1:0] REQ_RT,
  input  logic [ADDR_WIDTH-1:0] REQ_RD,
  input  logic                  REQ_WB,
  output logic                  OPND_VALID,
  input  logic                  OPND_READY,
  output logic [DATA_WIDTH-1:0] OPND_A,
  output logic [DATA_WIDTH-1:0] OPND_B,
  input  logic                  RES_VALID,
  output logic                  RES_READY,
  input  logic [DATA_WIDTH-1:0] RES_DATA,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
  output logic [DATA_WIDTH-1:0] RF_DATA_W,
  output logic                  RF_READ,
  output logic                  RF_WRITE,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R2,
  output logic                  BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_OPND,
    S_WAIT_RES,
    S_WRITE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic                  r_wb;
  logic [DATA_WIDTH-1:0] w_opnd_a;
  logic [DATA_WIDTH-1:0] w_opnd_b;
  logic                  w_wr_en;

  // RF_ADDR_R1/R2 hold the latched rs/rt for the whole transaction.
`ifdef RF_ACCESS_ZERO_REG_EN
  assign w_opnd_a = (RF_ADDR_R1 == '0) ? '0 : RF_DATA_R1;
  assign w_opnd_b = (RF_ADDR_R2 == '0) ? '0 : RF_DATA_R2;
  assign w_wr_en  = (r_rd != '0);
`else
  assign w_opnd_a = RF_DATA_R1;
  assign w_opnd_b = RF_DATA_R2;
  assign w_wr_en  = 1'b1;
`endif

  assign REQ_READY = (r_state == S_IDLE) & RST;
  assign RES_READY = (r_state == S_WAIT_RES);
  assign BUSY      = (r_state != S_IDLE);

  // Transaction sequencer; all RF strobes and operands are registered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_rd       <= '0;
      r_wb       <= 1'b0;
      OPND_VALID <= 1'b0;
      OPND_A     <= '0;
      OPND_B     <= '0;
      RF_ADDR_R1 <= '0;
      RF_ADDR_R2 <= '0;
      RF_ADDR_W  <= '0;
      RF_DATA_W  <= '0;
      RF_READ    <= 1'b0;
      RF_WRITE   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (REQ_VALID) begin
            RF_ADDR_R1 <= REQ_RS;
            RF_ADDR_R2 <= REQ_RT;
            r_rd       <= REQ_RD;
            r_wb       <= REQ_WB;
            RF_READ    <= 1'b1;
            r_state    <= S_READ;
          end
        end
        S_READ: begin
          OPND_A     <= w_opnd_a;
          OPND_B     <= w_opnd_b;
          OPND_VALID <= 1'b1;
          RF_READ    <= 1'b0;
          r_state    <= S_OPND;
        end
        S_OPND: begin
          if (OPND_READY) begin
            OPND_VALID <= 1'b0;
            r_state    <= r_wb ? S_WAIT_RES : S_IDLE;
          end
        end
        S_WAIT_RES: begin
          if (RES_VALID) begin
            if (w_wr_en) begin
              RF_DATA_W <= RES_DATA;
              RF_ADDR_W <= r_rd;
              RF_WRITE  <= 1'b1;
              r_state   <= S_WRITE;
            end else begin
              r_state   <= S_IDLE;
            end
          end
        end
        S_WRITE: begin
          RF_WRITE <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb_rf_access_ctrl: directed + random transactions against a
// transaction-level register-file model.
module tb_rf_access_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [4:0]  REQ_RS = '0;
  logic [4:0]  REQ_RT = '0;
  logic [4:0]  REQ_RD = '0;
  logic        REQ_WB = 1'b0;
  logic        OPND_VALID;
  logic        OPND_READY = 1'b0;
  logic [31:0] OPND_A;
  logic [31:0] OPND_B;
  logic        RES_VALID = 1'b0;
  logic        RES_READY;
  logic [31:0] RES_DATA = '0;
  logic [4:0]  RF_ADDR_R1;
  logic [4:0]  RF_ADDR_R2;
  logic [4:0]  RF_ADDR_W;
  logic [31:0] RF_DATA_W;
  logic        RF_READ;
  logic        RF_WRITE;
  logic [31:0] RF_DATA_R1;
  logic [31:0] RF_DATA_R2;
  logic        BUSY;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;

  logic [31:0] rf [32];
  logic [31:0] exp_rf [32];

  logic [4:0] nxt_rs, nxt_rt, nxt_rd;
  logic       nxt_wb;

  rf_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_RS(REQ_RS), .REQ_RT(REQ_RT), .REQ_RD(REQ_RD),
    .REQ_WB(REQ_WB),
    .OPND_VALID(OPND_VALID), .OPND_READY(OPND_READY),
    .OPND_A(OPND_A), .OPND_B(OPND_B),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_DATA(RES_DATA),
    .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2),
    .RF_ADDR_W(RF_ADDR_W), .RF_DATA_W(RF_DATA_W),
    .RF_READ(RF_READ), .RF_WRITE(RF_WRITE),
    .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Register file stand-in; a junk pattern replaces the floating bus.
  assign RF_DATA_R1 = RF_READ ? rf[RF_ADDR_R1] : 32'hBAD0_BAD0;
  assign RF_DATA_R2 = RF_READ ? rf[RF_ADDR_R2] : 32'hBAD1_BAD1;

  always @(posedge CLK) begin
    if (RF_WRITE) begin
      rf[RF_ADDR_W] <= RF_DATA_W;
      n_wr = n_wr + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge CLK)
    chk("rd_wr_excl", {31'b0, RF_READ & RF_WRITE}, 32'd0);

  function automatic logic [31:0] model_rd(input logic [4:0] a);
`ifdef RF_ACCESS_ZERO_REG_EN
    if (a == 5'd0) return 32'd0;
`endif
    return exp_rf[a];
  endfunction

  function automatic bit model_wr_en(input logic [4:0] a);
`ifdef RF_ACCESS_ZERO_REG_EN
    return a != 5'd0;
`else
    return (a == a);
`endif
  endfunction

  // Called at a falling edge; returns at a falling edge.
  task automatic do_txn(input logic [4:0] rs, rt, rd,
                        input logic wb,
                        input logic [31:0] res,
                        input int stall, rdel,
                        input bit hold, rst_w);
    logic [31:0] ea, eb;
    int n, w0;
    bit we;
    REQ_RS = rs; REQ_RT = rt; REQ_RD = rd;
    REQ_WB = wb; REQ_VALID = 1'b1;
    n = 0;
    while (!REQ_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("req_accept", {31'b0, REQ_READY}, 32'd1);
    ea = model_rd(rs);
    eb = model_rd(rt);
    @(posedge CLK); #1;
    if (hold) begin
      REQ_RS = nxt_rs; REQ_RT = nxt_rt;
      REQ_RD = nxt_rd; REQ_WB = nxt_wb;
    end else begin
      REQ_VALID = 1'b0;
    end
    @(negedge CLK);
    chk("read_pulse", {31'b0, RF_READ}, 32'd1);
    chk("addr_r1", {27'b0, RF_ADDR_R1}, {27'b0, rs});
    chk("addr_r2", {27'b0, RF_ADDR_R2}, {27'b0, rt});
    chk("opnd_early", {31'b0, OPND_VALID}, 32'd0);
    chk("busy_rd", {31'b0, BUSY}, 32'd1);
    @(negedge CLK);
    chk("read_drop", {31'b0, RF_READ}, 32'd0);
    chk("opnd_valid", {31'b0, OPND_VALID}, 32'd1);
    chk("opnd_a", OPND_A, ea);
    chk("opnd_b", OPND_B, eb);
    for (int k = 0; k < stall; k++) begin
      RES_VALID = 1'($urandom_range(0, 1));
      RES_DATA = $urandom;
      @(negedge CLK);
      chk("opnd_hold_v", {31'b0, OPND_VALID}, 32'd1);
      chk("opnd_hold_a", OPND_A, ea);
      chk("opnd_hold_b", OPND_B, eb);
    end
    RES_VALID = 1'b0;
    OPND_READY = 1'b1;
    @(posedge CLK); #1;
    OPND_READY = 1'b0;
    @(negedge CLK);
    chk("opnd_drop", {31'b0, OPND_VALID}, 32'd0);
    if (!wb) begin
      chk("ro_idle", {31'b0, REQ_READY}, 32'd1);
      chk("ro_busy", {31'b0, BUSY}, 32'd0);
      return;
    end
    chk("res_ready", {31'b0, RES_READY}, 32'd1);
    for (int k = 0; k < rdel; k++) begin
      OPND_READY = 1'($urandom_range(0, 1));
      @(negedge CLK);
      chk("res_wait", {31'b0, RES_READY}, 32'd1);
      chk("no_early_wr", {31'b0, RF_WRITE}, 32'd0);
    end
    OPND_READY = 1'b0;
    RES_DATA = res;
    RES_VALID = 1'b1;
    w0 = n_wr;
    @(posedge CLK); #1;
    RES_VALID = 1'b0;
    RES_DATA = $urandom;
    @(negedge CLK);
    we = model_wr_en(rd);
    chk("wr_pulse", {31'b0, RF_WRITE}, {31'b0, we});
    if (!we) begin
      chk("zr_idle", {31'b0, REQ_READY}, 32'd1);
      chk("zr_nowr", n_wr - w0, 32'd0);
      return;
    end
    chk("addr_w", {27'b0, RF_ADDR_W}, {27'b0, rd});
    chk("data_w", RF_DATA_W, res);
    chk("wr_busy", {31'b0, REQ_READY}, 32'd0);
    if (rst_w) begin
      RST = 1'b0;
      #1;
      chk("rst_wr_drop", {31'b0, RF_WRITE}, 32'd0);
      chk("rst_busy", {31'b0, BUSY}, 32'd0);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(negedge CLK);
      chk("rst_idle", {31'b0, REQ_READY}, 32'd1);
      chk("rst_nowr", n_wr - w0, 32'd0);
      return;
    end
    @(negedge CLK);
    chk("wr_end", {31'b0, RF_WRITE}, 32'd0);
    chk("post_wr_ready", {31'b0, REQ_READY}, 32'd1);
    chk("wr_count", n_wr - w0, 32'd1);
    exp_rf[rd] = res;
  endtask

  initial begin
    logic [4:0] p_rs, p_rt, p_rd;
    logic       p_wb;
    bit         h;
    for (int i = 0; i < 32; i++) begin
      rf[i] = $urandom;
      exp_rf[i] = rf[i];
    end
    rf[0] = 32'h5555_5555; exp_rf[0] = rf[0];
    rf[3] = 32'h0000_00AA; exp_rf[3] = rf[3];
    rf[7] = 32'h1234_5678; exp_rf[7] = rf[7];

    repeat (2) begin
      @(negedge CLK);
      chk("rst_req_ready", {31'b0, REQ_READY}, 32'd0);
      chk("rst_rf_read", {31'b0, RF_READ}, 32'd0);
      chk("rst_opnd_v", {31'b0, OPND_VALID}, 32'd0);
      chk("rst_opnd_a", OPND_A, 32'd0);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("idle_ready", {31'b0, REQ_READY}, 32'd1);
    chk("idle_busy", {31'b0, BUSY}, 32'd0);
    chk("idle_read", {31'b0, RF_READ}, 32'd0);
    chk("idle_write", {31'b0, RF_WRITE}, 32'd0);
    chk("idle_opnd_v", {31'b0, OPND_VALID}, 32'd0);
    chk("idle_res_rdy", {31'b0, RES_READY}, 32'd0);

    do_txn(5'd3, 5'd7, 5'd0, 1'b0, 32'd0, 0, 0, 1'b0, 1'b0);
    do_txn(5'd1, 5'd2, 5'd9, 1'b1, 32'hDEAD_BEEF, 3, 4, 1'b0, 1'b0);
    do_txn(5'd9, 5'd3, 5'd0, 1'b0, 32'd0, 0, 0, 1'b0, 1'b0);
    chk("r9_model", exp_rf[9], 32'hDEAD_BEEF);

    nxt_rs = 5'd12; nxt_rt = 5'd5; nxt_rd = 5'd13; nxt_wb = 1'b0;
    do_txn(5'd5, 5'd6, 5'd12, 1'b1, 32'hCAFE_F00D, 1, 2, 1'b1, 1'b0);
    do_txn(5'd12, 5'd5, 5'd13, 1'b0, 32'd0, 0, 0, 1'b0, 1'b0);

    do_txn(5'd4, 5'd4, 5'd8, 1'b1, 32'h1111_1111, 0, 1, 1'b0, 1'b1);
    do_txn(5'd8, 5'd0, 5'd0, 1'b0, 32'd0, 0, 0, 1'b0, 1'b0);

    do_txn(5'd0, 5'd0, 5'd0, 1'b1, 32'hA5A5_A5A5, 0, 1, 1'b0, 1'b0);
    do_txn(5'd0, 5'd9, 5'd1, 1'b0, 32'd0, 0, 0, 1'b0, 1'b0);

    p_rs = 5'($urandom); p_rt = 5'($urandom);
    p_rd = 5'($urandom); p_wb = 1'($urandom);
    for (int t = 0; t < 60; t++) begin
      nxt_rs = 5'($urandom); nxt_rt = 5'($urandom);
      nxt_rd = 5'($urandom); nxt_wb = 1'($urandom);
      h = 1'($urandom);
      do_txn(p_rs, p_rt, p_rd, p_wb, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), h, 1'b0);
      p_rs = nxt_rs; p_rt = nxt_rt; p_rd = nxt_rd; p_wb = nxt_wb;
    end
    REQ_VALID = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 32; i++)
      chk("rf_final", rf[i], exp_rf[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
